ecc_44_wr_enc: RTL and testbench
================================

// Module: ecc_44_wr_enc
// PURPOSE
//  - Write-side SECDED encoder for the 44-bit ECC-protected FIFO RAM.
//  - Accepts 44-bit words over a valid/ready handshake and appends 7 check bits.
//  - Drives the codeword to the RAM write port through a 2-entry output buffer.
//  - The check/correct path on the RAM read port decodes the codeword.
//  - Provides armed one-shot single/double-bit error injection for verifying the read-side decoder.
// PARAMETERS
//  CNT_W   16  width of accepted-word counter enc_cnt
// PORTS
//  clk          in   1   clock; all logic rising-edge
//  rst          in   1   synchronous active-high reset
//  in_vld       in   1   input word valid
//  in_rdy       out  1   encoder can accept (occupancy < 2)
//  in_data      in   44  input data
//  out_vld      out  1   codeword valid to RAM write port
//  out_rdy      in   1   RAM write port accepts
//  out_data     out  44  codeword data bits
//  out_parity   out  7   codeword check bits
//  inj_arm      in   1   1-cycle pulse: arm error injection, latch inj_*
//  inj_dbl      in   1   0 = flip inj_pos0 only; 1 = flip inj_pos0 and inj_pos1
//  inj_pos0     in   6   codeword bit index 0..50 (0-43 data, 44-50 parity[0..6])
//  inj_pos1     in   6   second index (double mode)
//  inj_armed    out  1   injection pending
//  inj_done     out  1   1-cycle pulse: corrupted word accepted on input
//  enc_cnt      out  CNT_W  accepted input words, wraps
// BEHAVIOUR
//  - Reset: buffer empty, out_vld=0, in_rdy=1, out_data/out_parity=0, inj_armed=0, inj_done=0, enc_cnt=0.
//  - Reset asserted mid-transfer discards buffered words without output.
//  - Encoding matrix column for data bit k:
//    - Bits [5:0] hold the k-th integer in the ascending list 3,5,6,7,9,10,...,50.
//    - The list contains all values 3..50 except 4, 8, 16, 32.
//    - Bit 6 is set iff bits [5:0] have even weight, so every column has odd weight.
//  - parity[j] = XOR of all d[k] whose column has bit j set.
//  - Reference columns: d0 -> 7'b1000011, d3 -> 7'b0000111, d43 -> 7'b0110010.
//  - Handshake:
//    - Input accept when in_vld & in_rdy.
//    - Output transfer when out_vld & out_rdy.
//    - out_data, out_parity and out_vld hold stable while out_vld & !out_rdy.
//  - Buffer: 2-entry FIFO of 51-bit codewords, encoded before storage.
//    - Latency: accepted word appears at the output 1 cycle later when the buffer is empty.
//    - Throughput: 1 word/cycle.
//    - in_rdy = (occupancy < 2), driven from registered occupancy only, with no combinational path from out_rdy.
//    - Push and pop in the same cycle at occupancy 1 leaves occupancy 1.
//    - Order is strictly preserved.
//  - Injection FSM: IDLE / ARMED.
//    - IDLE -> ARMED on inj_arm; latch inj_dbl/inj_pos0/inj_pos1.
//    - ARMED + inj_arm re-latches the parameters and stays ARMED.
//    - ARMED + input accept: XOR the stored codeword with the flip mask, pulse inj_done, go to IDLE.
//    - inj_arm and accept in the same cycle in IDLE: the current word is clean; the next accepted word is corrupted.
//    - inj_arm and accept in the same cycle in ARMED: the current word uses the old parameters; new parameters are latched and the FSM stays ARMED.
//    - Index > 50 flips nothing.
//    - Double mode with pos0 == pos1 flips nothing; inj_done still pulses.
//  - inj_armed = (state == ARMED).
//  - enc_cnt increments on every accept and wraps from 2^CNT_W-1 to 0.
// TESTING
//  - Data 44'h0 -> parity 7'h00. Data 44'h1 -> 7'b1000011. Data bit43 only -> 7'b0110010. Data all-ones -> parity equal to the XOR of all 44 columns.
//  - Single inject: inj_arm, pos0=5, data 0 -> out_data=44'h20, parity 0, inj_done one cycle; next word clean; read-side decode flags sbit_err.
//  - Double inject: pos0=0, pos1=47, data 0 -> out_data=44'h1, parity=7'b0001000; read-side decode flags dbit_err.
//  - Backpressure: out_rdy=0, push A,B,C -> A,B accepted, in_rdy=0 and C stalls; release out_rdy -> A,B,C emitted in order; enc_cnt=3.
//  - Streaming: in_vld=out_rdy=1 for 100 cycles -> 100 words out at 1/cycle with latency 1; enc_cnt=100.
//  - Reset mid-stream with occupancy 2 and ARMED -> next cycle out_vld=0, in_rdy=1, inj_armed=0, enc_cnt=0; no stale word emitted.

Source files
------------

// File: rtl/ecc_44_wr_enc_if.sv
// rtl/ecc_44_wr_enc_if.sv - word-in / codeword-out handshake bundle for the write-side SECDED encoder
// Purpose: groups the input word stream and the RAM write-port codeword stream.
// Signals:
//   in_vld/in_rdy/in_data            44-bit input word handshake
//   out_vld/out_rdy/out_data/out_parity  51-bit codeword handshake to RAM write port
// Modports: master = producer/RAM side (testbench), slave = encoder side.
interface ecc_44_wr_enc_if;
  logic        in_vld;
  logic        in_rdy;
  logic [43:0] in_data;
  logic        out_vld;
  logic        out_rdy;
  logic [43:0] out_data;
  logic [6:0]  out_parity;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_parity
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_parity
  );
endinterface

// File: rtl/ecc_44_wr_enc.sv
// rtl/ecc_44_wr_enc.sv - write-side SECDED (51,44) encoder with 2-entry buffer and error injection
// Purpose: encodes 44-bit words into 51-bit codewords (7 check bits), buffers up to two
//   codewords for the RAM write port, and optionally corrupts one accepted word with a
//   single or double bit flip so the read-side decoder can be exercised.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     in_vld/in_rdy/in_data input word, out_vld/out_rdy/out_data/out_parity codeword
//   inj_arm         1-cycle pulse arming injection, latches inj_dbl/inj_pos0/inj_pos1
//   inj_dbl         0 = flip pos0 only, 1 = flip pos0 and pos1
//   inj_pos0/1      codeword bit index (0-43 data, 44-50 parity[0..6]), >50 flips nothing
//   inj_armed       injection pending
//   inj_done        1-cycle pulse, corrupted word was accepted
//   enc_cnt         count of accepted words, wraps
module ecc_44_wr_enc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  ecc_44_wr_enc_if.slave   bus,
  input  logic             inj_arm,
  input  logic             inj_dbl,
  input  logic [5:0]       inj_pos0,
  input  logic [5:0]       inj_pos1,
  output logic             inj_armed,
  output logic             inj_done,
  output logic [CNT_W-1:0] enc_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } inj_state_e;

  // Column k: low 6 bits walk 3..50 skipping powers of two (those are the
  // parity-bit positions of a Hamming code); bit 6 forces odd column weight
  // so single errors give odd syndromes and double errors even ones.
  function automatic logic [43:0][6:0] gen_cols();
    logic [43:0][6:0] c;
    logic [5:0]       k;
    logic [5:0]       v;
    c = '0;
    k = '0;
    for (int i = 3; i <= 50; i++) begin
      v = 6'(i);
      if (i != 4 && i != 8 && i != 16 && i != 32) begin
        c[k] = {~(^v), v};
        k    = k + 6'd1;
      end
    end
    return c;
  endfunction

  localparam logic [43:0][6:0] COLS = gen_cols();

  function automatic logic [6:0] enc_parity(input logic [43:0] d);
    logic [6:0] p;
    p = '0;
    for (int k = 0; k < 44; k++) begin
      if (d[k]) p = p ^ COLS[k];
    end
    return p;
  endfunction

  function automatic logic [50:0] flip_bit(input logic [5:0] pos);
    logic [50:0] m;
    m = '0;
    if (pos <= 6'd50) m[pos] = 1'b1;
    return m;
  endfunction

  logic [50:0]      mem_q [2];
  logic [50:0]      mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  inj_state_e       state_q, state_d;
  logic             inj_dbl_q, inj_dbl_d;
  logic [5:0]       inj_pos0_q, inj_pos0_d;
  logic [5:0]       inj_pos1_q, inj_pos1_d;
  logic             inj_done_q, inj_done_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;

  logic             push;
  logic             pop;
  logic [50:0]      code;
  logic [50:0]      mask;

  // Ready and valid come from registered occupancy only; out_rdy never reaches in_rdy.
  assign bus.in_rdy     = (occ_q != 2'd2);
  assign bus.out_vld    = (occ_q != 2'd0);
  assign bus.out_data   = mem_q[rd_ptr_q][43:0];
  assign bus.out_parity = mem_q[rd_ptr_q][50:44];
  assign inj_armed      = (state_q == S_ARMED);
  assign inj_done       = inj_done_q;
  assign enc_cnt        = enc_cnt_q;

  always_comb begin
    push = bus.in_vld & bus.in_rdy;
    pop  = bus.out_vld & bus.out_rdy;
    code = {enc_parity(bus.in_data), bus.in_data};

    // Equal double positions cancel in the XOR, which is the intended "flip nothing".
    mask = '0;
    if (state_q == S_ARMED) begin
      mask = flip_bit(inj_pos0_q) ^ (inj_dbl_q ? flip_bit(inj_pos1_q) : 51'd0);
    end

    mem_d[0]   = mem_q[0];
    mem_d[1]   = mem_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    state_d    = state_q;
    inj_dbl_d  = inj_dbl_q;
    inj_pos0_d = inj_pos0_q;
    inj_pos1_d = inj_pos1_q;
    inj_done_d = 1'b0;
    enc_cnt_d  = enc_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = code ^ mask;
      wr_ptr_d        = ~wr_ptr_q;
      enc_cnt_d       = enc_cnt_q + 1'b1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // The word accepted this cycle always uses the parameters already latched;
    // a simultaneous arm only affects later words.
    if (push && state_q == S_ARMED) begin
      inj_done_d = 1'b1;
      state_d    = S_IDLE;
    end
    if (inj_arm) begin
      state_d    = S_ARMED;
      inj_dbl_d  = inj_dbl;
      inj_pos0_d = inj_pos0;
      inj_pos1_d = inj_pos1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      state_q    <= S_IDLE;
      inj_dbl_q  <= 1'b0;
      inj_pos0_q <= '0;
      inj_pos1_q <= '0;
      inj_done_q <= 1'b0;
      enc_cnt_q  <= '0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      state_q    <= state_d;
      inj_dbl_q  <= inj_dbl_d;
      inj_pos0_q <= inj_pos0_d;
      inj_pos1_q <= inj_pos1_d;
      inj_done_q <= inj_done_d;
      enc_cnt_q  <= enc_cnt_d;
    end
  end

endmodule

// File: tb/tb_ecc_44_wr_enc.sv
// tb/tb_ecc_44_wr_enc.sv - directed self-checking bench for ecc_44_wr_enc
module tb_ecc_44_wr_enc;
  logic        clk;
  logic        rst;
  logic        inj_arm;
  logic        inj_dbl;
  logic [5:0]  inj_pos0;
  logic [5:0]  inj_pos1;
  logic        inj_armed;
  logic        inj_done;
  logic [15:0] enc_cnt;
  int          n_cmp;
  int          n_bad;

  ecc_44_wr_enc_if bus ();

  ecc_44_wr_enc #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .inj_arm   (inj_arm),
    .inj_dbl   (inj_dbl),
    .inj_pos0  (inj_pos0),
    .inj_pos1  (inj_pos1),
    .inj_armed (inj_armed),
    .inj_done  (inj_done),
    .enc_cnt   (enc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
    inj_arm = 1'b0; inj_dbl = 1'b0; inj_pos0 = '0; inj_pos1 = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL rst_out_vld got %b want 0", bus.out_vld); end
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_in_rdy got %b want 1", bus.in_rdy); end
    n_cmp++; if (bus.out_data !== 44'h0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_parity !== 7'h0) begin n_bad++; $display("FAIL rst_out_parity got %h want 0", bus.out_parity); end
    n_cmp++; if (inj_armed !== 1'b0) begin n_bad++; $display("FAIL rst_inj_armed got %b want 0", inj_armed); end
    n_cmp++; if (inj_done !== 1'b0) begin n_bad++; $display("FAIL rst_inj_done got %b want 0", inj_done); end
    n_cmp++; if (enc_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_enc_cnt got %0d want 0", enc_cnt); end
  endtask

  // Back-to-back encode vectors; parities hand-derived from the column list.
  task automatic test_encode();
    logic [43:0] vd [6];
    logic [6:0]  vp [6];
    vd[0] = 44'h0;           vp[0] = 7'h00;
    vd[1] = 44'h1;           vp[1] = 7'h43;
    vd[2] = 44'h8;           vp[2] = 7'h07;
    vd[3] = 44'h800_0000_0000; vp[3] = 7'h32;
    vd[4] = 44'hFFF_FFFF_FFFF; vp[4] = 7'h0C;
    vd[5] = 44'h3;           vp[5] = 7'h06;
    do_reset();
    bus.out_rdy = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_bad++; $display("FAIL enc_vld[%0d] got %b want 1", i-1, bus.out_vld); end
        n_cmp++; if (bus.out_data !== vd[i-1]) begin n_bad++; $display("FAIL enc_data[%0d] got %h want %h", i-1, bus.out_data, vd[i-1]); end
        n_cmp++; if (bus.out_parity !== vp[i-1]) begin n_bad++; $display("FAIL enc_parity[%0d] got %b want %b", i-1, bus.out_parity, vp[i-1]); end
      end
      if (i < 6) begin bus.in_vld = 1'b1; bus.in_data = vd[i]; end
      else bus.in_vld = 1'b0;
    end
    n_cmp++; if (enc_cnt !== 16'd6) begin n_bad++; $display("FAIL enc_cnt got %0d want 6", enc_cnt); end
  endtask

  task automatic test_single_inject();
    logic [6:0] syn;
    do_reset();
    bus.out_rdy = 1'b1;
    inj_arm = 1'b1; inj_dbl = 1'b0; inj_pos0 = 6'd5;
    @(negedge clk);
    inj_arm = 1'b0;
    n_cmp++; if (inj_armed !== 1'b1) begin n_bad++; $display("FAIL sgl_armed got %b want 1", inj_armed); end
    bus.in_vld = 1'b1; bus.in_data = 44'h0;
    @(negedge clk);
    n_cmp++; if (inj_done !== 1'b1) begin n_bad++; $display("FAIL sgl_done got %b want 1", inj_done); end
    n_cmp++; if (bus.out_data !== 44'h20) begin n_bad++; $display("FAIL sgl_data got %h want 20", bus.out_data); end
    n_cmp++; if (bus.out_parity !== 7'h00) begin n_bad++; $display("FAIL sgl_parity got %h want 0", bus.out_parity); end
    n_cmp++; if (inj_armed !== 1'b0) begin n_bad++; $display("FAIL sgl_disarm got %b want 0", inj_armed); end
    // Clean parity of data 0x20 is column d5 = 7'h4A; syndrome of odd weight means single error.
    syn = 7'h4A ^ bus.out_parity;
    n_cmp++; if ((^syn) !== 1'b1) begin n_bad++; $display("FAIL sgl_sbit syndrome %b got even want odd", syn); end
    @(negedge clk);
    n_cmp++; if (inj_done !== 1'b0) begin n_bad++; $display("FAIL sgl_done2 got %b want 0", inj_done); end
    n_cmp++; if (bus.out_data !== 44'h0 || bus.out_parity !== 7'h0) begin n_bad++; $display("FAIL sgl_next_clean got %h/%h want 0/0", bus.out_data, bus.out_parity); end
    bus.in_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_double_inject();
    logic [6:0] syn;
    do_reset();
    bus.out_rdy = 1'b1;
    inj_arm = 1'b1; inj_dbl = 1'b1; inj_pos0 = 6'd0; inj_pos1 = 6'd47;
    @(negedge clk);
    inj_arm = 1'b0;
    bus.in_vld = 1'b1; bus.in_data = 44'h0;
    @(negedge clk);
    bus.in_vld = 1'b0;
    n_cmp++; if (inj_done !== 1'b1) begin n_bad++; $display("FAIL dbl_done got %b want 1", inj_done); end
    n_cmp++; if (bus.out_data !== 44'h1) begin n_bad++; $display("FAIL dbl_data got %h want 1", bus.out_data); end
    n_cmp++; if (bus.out_parity !== 7'b0001000) begin n_bad++; $display("FAIL dbl_parity got %b want 0001000", bus.out_parity); end
    // Clean parity of data 0x1 is 7'h43; nonzero even-weight syndrome means double error.
    syn = 7'h43 ^ bus.out_parity;
    n_cmp++; if (syn == 7'h0 || (^syn) !== 1'b0) begin n_bad++; $display("FAIL dbl_dbit syndrome got %b want nonzero even", syn); end
    @(negedge clk);
  endtask

  task automatic test_inject_corner();
    do_reset();
    bus.out_rdy = 1'b1;
    inj_arm = 1'b1; inj_dbl = 1'b0; inj_pos0 = 6'd55;
    @(negedge clk);
    inj_arm = 1'b0; bus.in_vld = 1'b1; bus.in_data = 44'h1;
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 44'h1 || bus.out_parity !== 7'h43 || inj_done !== 1'b1) begin n_bad++; $display("FAIL oob_pos got %h/%h/%b want 1/43/1", bus.out_data, bus.out_parity, inj_done); end
    inj_arm = 1'b1; inj_dbl = 1'b1; inj_pos0 = 6'd9; inj_pos1 = 6'd9; bus.in_vld = 1'b0;
    @(negedge clk);
    inj_arm = 1'b0; bus.in_vld = 1'b1; bus.in_data = 44'h8;
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 44'h8 || bus.out_parity !== 7'h07 || inj_done !== 1'b1) begin n_bad++; $display("FAIL same_pos got %h/%h/%b want 8/07/1", bus.out_data, bus.out_parity, inj_done); end
    // Arm and accept together in IDLE: this word clean, the next one corrupted.
    inj_arm = 1'b1; inj_dbl = 1'b0; inj_pos0 = 6'd0; bus.in_data = 44'h8;
    @(negedge clk);
    inj_arm = 1'b0;
    n_cmp++; if (bus.out_data !== 44'h8 || inj_done !== 1'b0 || inj_armed !== 1'b1) begin n_bad++; $display("FAIL idle_arm_acc got %h/%b/%b want 8/0/1", bus.out_data, inj_done, inj_armed); end
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 44'h9 || bus.out_parity !== 7'h07 || inj_done !== 1'b1) begin n_bad++; $display("FAIL idle_arm_next got %h/%h/%b want 9/07/1", bus.out_data, bus.out_parity, inj_done); end
    // Arm and accept together in ARMED: old position used, new one latched.
    inj_arm = 1'b1; inj_pos0 = 6'd1; bus.in_vld = 1'b0;
    @(negedge clk);
    inj_arm = 1'b1; inj_pos0 = 6'd2; bus.in_vld = 1'b1; bus.in_data = 44'h0;
    @(negedge clk);
    inj_arm = 1'b0;
    n_cmp++; if (bus.out_data !== 44'h2 || inj_done !== 1'b1 || inj_armed !== 1'b1) begin n_bad++; $display("FAIL armed_arm_acc got %h/%b/%b want 2/1/1", bus.out_data, inj_done, inj_armed); end
    @(negedge clk);
    bus.in_vld = 1'b0;
    n_cmp++; if (bus.out_data !== 44'h4 || inj_done !== 1'b1 || inj_armed !== 1'b0) begin n_bad++; $display("FAIL armed_relatch got %h/%b/%b want 4/1/0", bus.out_data, inj_done, inj_armed); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_rdy = 1'b0;
    bus.in_vld = 1'b1; bus.in_data = 44'h1;
    @(negedge clk);
    bus.in_data = 44'h8;
    @(negedge clk);
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_full got %b want 0", bus.in_rdy); end
    bus.in_data = 44'h800_0000_0000;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_data !== 44'h1 || bus.out_parity !== 7'h43) begin n_bad++; $display("FAIL bp_hold got %b/%h/%h want 1/1/43", bus.out_vld, bus.out_data, bus.out_parity); end
    end
    n_cmp++; if (enc_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_cnt2 got %0d want 2", enc_cnt); end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 44'h8 || bus.out_parity !== 7'h07) begin n_bad++; $display("FAIL bp_B got %h/%h want 8/07", bus.out_data, bus.out_parity); end
    @(negedge clk);
    bus.in_vld = 1'b0;
    n_cmp++; if (bus.out_data !== 44'h800_0000_0000 || bus.out_parity !== 7'h32) begin n_bad++; $display("FAIL bp_C got %h/%h want 80000000000/32", bus.out_data, bus.out_parity); end
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", bus.out_vld); end
    n_cmp++; if (enc_cnt !== 16'd3) begin n_bad++; $display("FAIL bp_cnt got %0d want 3", enc_cnt); end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.out_rdy = 1'b1;
    bus.in_vld = 1'b1; bus.in_data = 44'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_data !== 44'(i)) begin n_bad++; $display("FAIL stream[%0d] got %b/%h want 1/%h", i, bus.out_vld, bus.out_data, 44'(i)); end
      if (i < 99) bus.in_data = 44'(i + 1);
      else bus.in_vld = 1'b0;
    end
    n_cmp++; if (enc_cnt !== 16'd100) begin n_bad++; $display("FAIL stream_cnt got %0d want 100", enc_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL stream_drain got %b want 0", bus.out_vld); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_rdy = 1'b0;
    bus.in_vld = 1'b1; bus.in_data = 44'h1;
    @(negedge clk);
    bus.in_data = 44'h2;
    @(negedge clk);
    bus.in_vld = 1'b0;
    inj_arm = 1'b1; inj_pos0 = 6'd3;
    @(negedge clk);
    inj_arm = 1'b0;
    n_cmp++; if (inj_armed !== 1'b1 || bus.in_rdy !== 1'b0) begin n_bad++; $display("FAIL rm_pre got %b/%b want 1/0", inj_armed, bus.in_rdy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL rm_out_vld got %b want 0", bus.out_vld); end
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_bad++; $display("FAIL rm_in_rdy got %b want 1", bus.in_rdy); end
    n_cmp++; if (inj_armed !== 1'b0) begin n_bad++; $display("FAIL rm_armed got %b want 0", inj_armed); end
    n_cmp++; if (enc_cnt !== 16'd0) begin n_bad++; $display("FAIL rm_cnt got %0d want 0", enc_cnt); end
    bus.out_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL rm_stale got %b want 0", bus.out_vld); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
    inj_arm = 1'b0; inj_dbl = 1'b0; inj_pos0 = '0; inj_pos1 = '0;
    test_reset();
    test_encode();
    test_single_inject();
    test_double_inject();
    test_inject_corner();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
